rib_arb_n: RTL and testbench

//  Parametrised RIB interconnect: NUM_M masters to NUM_S slaves over one shared bus.

---
 rtl/rib_arb_n.sv | 207 ++++++++++++++++++++
 tb/tb_rib_arb_n.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rib_arb_n.sv
`default_nettype none
// ============================================================================
//  Module   : rib_arb_n
//  Brief    : Shared-bus RIB interconnect, NUM_M masters to NUM_S slaves.
//             Fixed-priority or round-robin arbitration, bounded bus lock,
//             1-cycle response routing and decode-error responses.
//  Revision : 1.0 - initial release
// ============================================================================
module rib_arb_n #(
    parameter int             NUM_M    = 4,
    parameter int             NUM_S    = 8,
    parameter int             AW       = 32,
    parameter int             DW       = 32,
    parameter int             SEL_W    = 4,
    parameter int             ARB_MODE = 1,
    parameter int             MAX_LOCK = 4,
    parameter logic [DW-1:0]  DECERR   = 32'hDEADBEEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_M-1:0]      m_req,
    input  logic [NUM_M-1:0]      m_we,
    input  logic [NUM_M-1:0]      m_lock,
    input  logic [NUM_M*AW-1:0]   m_addr,
    input  logic [NUM_M*DW-1:0]   m_wdata,
    output logic [NUM_M-1:0]      m_gnt,
    output logic [NUM_M-1:0]      m_hold,
    output logic [NUM_M-1:0]      m_rvalid,
    output logic [NUM_M-1:0]      m_err,
    output logic [DW-1:0]         m_rdata,
    output logic [NUM_S-1:0]      s_sel,
    output logic                  s_we,
    output logic [AW-1:0]         s_addr,
    output logic [DW-1:0]         s_wdata,
    input  logic [NUM_S*DW-1:0]   s_rdata
);

    localparam int PW  = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int LCW = $clog2(MAX_LOCK + 1);

    // Arbitration and lock state
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    owner_q, owner_d;
    logic             locked_q, locked_d;
    logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;

    // Response pipeline state (one transfer in flight)
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rsp_we_q, rsp_we_d;
    logic [SEL_W-1:0] rsp_slv_q, rsp_slv_d;
    logic [PW-1:0]    rsp_m_q, rsp_m_d;

    // Grant decision
    logic             gnt_any;
    logic             gnt_held;
    logic [PW-1:0]    gnt_idx;
    logic [NUM_M-1:0] cand;
    logic [NUM_M-1:0] others;

    // Address decode
    logic [SEL_W-1:0] dec_idx;
    logic             dec_ok;

    // Index (a + k) modulo NUM_M, used for round-robin search and pointer advance
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] a, input int k);
        return PW'((int'(a) + k) % NUM_M);
    endfunction

    // Grant selection: honour a live lock first, otherwise arbitrate among requesters
    always_comb begin
        gnt_any  = 1'b0;
        gnt_held = 1'b0;
        gnt_idx  = '0;
        cand     = m_req;
        others   = m_req;
        others[owner_q] = 1'b0;
        if (locked_q && m_req[owner_q] && (lock_cnt_q < LCW'(MAX_LOCK))) begin
            gnt_any  = 1'b1;
            gnt_held = 1'b1;
            gnt_idx  = owner_q;
        end else begin
            // An exhausted lock yields to any other requester; owner only wins if alone
            if (locked_q && m_req[owner_q] && (|others)) begin
                cand = others;
            end
            if (ARB_MODE == 0) begin
                for (int i = NUM_M - 1; i >= 0; i--) begin
                    if (cand[i]) begin
                        gnt_any = 1'b1;
                        gnt_idx = PW'(i);
                    end
                end
            end else begin
                for (int k = NUM_M - 1; k >= 0; k--) begin
                    if (cand[wrap_add(ptr_q, k)]) begin
                        gnt_any = 1'b1;
                        gnt_idx = wrap_add(ptr_q, k);
                    end
                end
            end
        end
    end

    // Master-side grant/stall and bus mux toward the slaves
    always_comb begin
        m_gnt   = '0;
        s_addr  = '0;
        s_wdata = '0;
        if (gnt_any) begin
            m_gnt[gnt_idx] = 1'b1;
            s_addr  = m_addr[gnt_idx*AW +: AW];
            s_wdata = m_wdata[gnt_idx*DW +: DW];
        end
        m_hold  = m_req & ~m_gnt;
        dec_idx = s_addr[AW-1 -: SEL_W];
        dec_ok  = (int'(dec_idx) < NUM_S);
    end

    // Slave strobes; out-of-range addresses strobe nothing and drop writes
    always_comb begin
        s_sel = '0;
        for (int s = 0; s < NUM_S; s++) begin
            if (gnt_any && dec_ok && (int'(dec_idx) == s)) begin
                s_sel[s] = 1'b1;
            end
        end
        s_we = gnt_any && dec_ok && m_we[gnt_idx];
    end

    // Next-state for arbitration, lock tracking and the response pipeline
    always_comb begin
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        locked_d   = locked_q;
        lock_cnt_d = lock_cnt_q;
        if (gnt_any) begin
            if (ARB_MODE == 1) begin
                ptr_d = wrap_add(gnt_idx, 1);
            end
            owner_d  = gnt_idx;
            locked_d = m_lock[gnt_idx];
            if (gnt_held) begin
                lock_cnt_d = (lock_cnt_q == LCW'(MAX_LOCK)) ? lock_cnt_q
                                                            : lock_cnt_q + LCW'(1);
            end else begin
                lock_cnt_d = LCW'(1);
            end
        end else begin
            locked_d = 1'b0;
        end
        rsp_valid_d = gnt_any;
        rsp_err_d   = gnt_any && !dec_ok;
        rsp_we_d    = gnt_any && m_we[gnt_idx];
        rsp_slv_d   = dec_idx;
        rsp_m_d     = gnt_idx;
    end

    // State registers; reset discards any pending response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            owner_q     <= '0;
            locked_q    <= 1'b0;
            lock_cnt_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_slv_q   <= '0;
            rsp_m_q     <= '0;
        end else begin
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            locked_q    <= locked_d;
            lock_cnt_q  <= lock_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_we_q    <= rsp_we_d;
            rsp_slv_q   <= rsp_slv_d;
            rsp_m_q     <= rsp_m_d;
        end
    end

    // Response routing back to the master that issued the previous-cycle transfer
    always_comb begin
        m_rvalid = '0;
        m_err    = '0;
        m_rdata  = '0;
        if (rsp_valid_q) begin
            m_rvalid[rsp_m_q] = 1'b1;
            m_err[rsp_m_q]    = rsp_err_q;
            if (!rsp_we_q) begin
                if (rsp_err_q) begin
                    m_rdata = DECERR;
                end else begin
                    for (int s = 0; s < NUM_S; s++) begin
                        if (int'(rsp_slv_q) == s) begin
                            m_rdata = s_rdata[s*DW +: DW];
                        end
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rib_arb_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rib_arb_n
//  Brief    : Scoreboard bench for rib_arb_n; a round-robin and a fixed-priority
//             instance share the same master stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rib_arb_n;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]   req, we, lock;
    logic [31:0]  addr  [4];
    logic [31:0]  wdata [4];
    logic [127:0] m_addr_f, m_wdata_f;
    logic [255:0] s_rdata_f;

    logic [3:0]  gnt_rr, hold_rr, rv_rr, err_rr;
    logic [31:0] rdata_rr, saddr_rr, swdata_rr;
    logic [7:0]  ssel_rr;
    logic        swe_rr;
    logic [3:0]  gnt_fp, hold_fp, rv_fp, err_fp;
    logic [31:0] rdata_fp, saddr_fp, swdata_fp;
    logic [7:0]  ssel_fp;
    logic        swe_fp;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  rv;
        logic [3:0]  err;
        logic [31:0] rdata;
    } rsp_t;
    rsp_t sb[$];

    // Flatten per-master buses
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            m_addr_f[i*32 +: 32]  = addr[i];
            m_wdata_f[i*32 +: 32] = wdata[i];
        end
    end

    function automatic logic [31:0] slv_val(input int k);
        return (k == 2) ? 32'h0000_A5A5 : (32'h5100_0000 | k);
    endfunction

    initial begin
        for (int k = 0; k < 8; k++) s_rdata_f[k*32 +: 32] = slv_val(k);
    end

    rib_arb_n #(.ARB_MODE(1)) dut_rr (
        .clk(clk), .rst(rst), .m_req(req), .m_we(we), .m_lock(lock),
        .m_addr(m_addr_f), .m_wdata(m_wdata_f), .m_gnt(gnt_rr), .m_hold(hold_rr),
        .m_rvalid(rv_rr), .m_err(err_rr), .m_rdata(rdata_rr), .s_sel(ssel_rr),
        .s_we(swe_rr), .s_addr(saddr_rr), .s_wdata(swdata_rr), .s_rdata(s_rdata_f)
    );

    rib_arb_n #(.ARB_MODE(0)) dut_fp (
        .clk(clk), .rst(rst), .m_req(req), .m_we(we), .m_lock(lock),
        .m_addr(m_addr_f), .m_wdata(m_wdata_f), .m_gnt(gnt_fp), .m_hold(hold_fp),
        .m_rvalid(rv_fp), .m_err(err_fp), .m_rdata(rdata_fp), .s_sel(ssel_fp),
        .s_we(swe_fp), .s_addr(saddr_fp), .s_wdata(swdata_fp), .s_rdata(s_rdata_f)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every response strobe must match the oldest queued expectation
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("rvalid", {28'd0, rv_rr}, {28'd0, e.rv});
                    chk("err", {28'd0, err_rr}, {28'd0, e.err});
                    chk("rdata", rdata_rr, e.rdata);
                end else begin
                    chk("rvalid_idle", {28'd0, rv_rr}, 32'd0);
                    chk("rdata_idle", rdata_rr, 32'd0);
                end
            end
        end
    end

    // One bus cycle: drive masters, check grants and slave side, queue the response
    task automatic cyc(input logic [3:0] r, input logic [3:0] w, input logic [3:0] l,
                       input logic [3:0] e_rr, input logic [3:0] e_fp);
        int g;
        logic [3:0] idx;
        logic bad;
        rsp_t e;
        @(negedge clk);
        req = r; we = w; lock = l;
        #1;
        chk("gnt_rr", {28'd0, gnt_rr}, {28'd0, e_rr});
        chk("hold_rr", {28'd0, hold_rr}, {28'd0, r & ~e_rr});
        chk("gnt_fp", {28'd0, gnt_fp}, {28'd0, e_fp});
        chk("hold_fp", {28'd0, hold_fp}, {28'd0, r & ~e_fp});
        if (e_rr == 4'd0) begin
            chk("s_sel_idle", {24'd0, ssel_rr}, 32'd0);
            chk("s_addr_idle", saddr_rr, 32'd0);
        end else begin
            g = 0;
            for (int i = 0; i < 4; i++) if (e_rr[i]) g = i;
            idx = addr[g][31:28];
            bad = (idx >= 4'd8);
            chk("s_addr", saddr_rr, addr[g]);
            chk("s_wdata", swdata_rr, wdata[g]);
            chk("s_sel", {24'd0, ssel_rr}, bad ? 32'd0 : (32'd1 << idx));
            chk("s_we", {31'd0, swe_rr}, {31'd0, w[g] & ~bad});
            e.rv    = e_rr;
            e.err   = bad ? e_rr : 4'd0;
            e.rdata = w[g] ? 32'd0 : (bad ? 32'hDEADBEEF : slv_val(int'(idx)));
            sb.push_back(e);
        end
    endtask

    task automatic do_reset();
        cyc(4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        logic [3:0] seq_rr [6];
        logic [3:0] seq_lk [11];
        req = '0; we = '0; lock = '0;
        for (int i = 0; i < 4; i++) begin
            addr[i]  = 32'h0000_0000 + i * 4;
            wdata[i] = 32'h1234_0000 + i;
        end
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;

        // Reset state: idle bus, no grants
        cyc(4'd0, 4'd0, 4'd0, 4'd0, 4'd0);

        // Reset asserted while a read is in flight
        addr[0] = 32'h0000_0100;
        addr[1] = 32'h1000_0104;
        @(negedge clk);
        req = 4'b0011;
        #1 chk("gnt_pre_rst", {28'd0, gnt_rr}, 32'd1);
        #1 rst = 1'b1;
        @(negedge clk);
        req = 4'b0000;
        #2 rst = 1'b0;
        cyc(4'b0011, 4'd0, 4'd0, 4'b0001, 4'b0001);
        cyc(4'd0, 4'd0, 4'd0, 4'd0, 4'd0);

        // Round-robin vs fixed priority with three requesters
        do_reset();
        addr[0] = 32'h0000_0000;
        addr[1] = 32'h1000_0000;
        addr[2] = 32'h3000_0000;
        seq_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0010, 4'b0100};
        for (int c = 0; c < 6; c++) cyc(4'b0111, 4'd0, 4'd0, seq_rr[c], 4'b0001);

        // Master 1 reads slave 2, then writes it back-to-back
        addr[1]  = 32'h2000_0010;
        wdata[1] = 32'hCAFE_F00D;
        cyc(4'b0010, 4'd0, 4'd0, 4'b0010, 4'b0010);
        cyc(4'b0010, 4'b0010, 4'd0, 4'b0010, 4'b0010);
        cyc(4'd0, 4'd0, 4'd0, 4'd0, 4'd0);

        // Bounded lock: m1 locks against a continuously requesting m0
        do_reset();
        addr[0] = 32'h0000_0000;
        addr[1] = 32'h1000_0000;
        seq_lk = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001,
                   4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
        for (int c = 0; c < 11; c++) cyc(4'b0011, 4'd0, 4'b0010, seq_lk[c], 4'b0001);
        // Lone locked requester keeps the bus past the lock limit
        for (int c = 0; c < 6; c++) cyc(4'b0010, 4'd0, 4'b0010, 4'b0010, 4'b0010);
        cyc(4'd0, 4'd0, 4'd0, 4'd0, 4'd0);

        // Decode error: read then write to an unmapped slave index
        addr[0] = 32'hF000_0000;
        cyc(4'b0001, 4'd0, 4'd0, 4'b0001, 4'b0001);
        cyc(4'b0001, 4'b0001, 4'd0, 4'b0001, 4'b0001);
        cyc(4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        cyc(4'd0, 4'd0, 4'd0, 4'd0, 4'd0);

        chk("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
